// File: rtl/mem_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_acc_pkg
// Purpose  : Shared definitions for the memory access sequencer: access-size
//            encodings, the sequencer state type and the alignment check.
// Revision : 1.0 - initial release
// ============================================================================
package mem_acc_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_RESP = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Natural alignment check; the illegal size code is handled by the caller.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_mux.sv
`default_nettype none
// ============================================================================
// Module   : lane_mux
// Purpose  : Combinational little-endian lane logic.
//            - Load path : picks the addressed byte/half from i_rd_word,
//                          right-aligns it and sign/zero-extends it.
//            - Store path: merges i_st_data into i_old_word at the addressed
//                          lane(s); a word store passes i_st_data through.
// Ports    : i_size, i_offset (addr[1:0]), i_uns, i_rd_word, i_old_word,
//            i_st_data -> o_ld_data, o_wr_word
// Revision : 1.0 - initial release
// ============================================================================
module lane_mux
  import mem_acc_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_uns,
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_wr_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rd_word[{i_offset, 3'b000} +: 8];
    w_half = i_rd_word[{i_offset[1], 4'b0000} +: 16];
    case (i_size)
      SZ_BYTE: o_ld_data = {{24{~i_uns & w_byte[7]}}, w_byte};
      SZ_HALF: o_ld_data = {{16{~i_uns & w_half[15]}}, w_half};
      default: o_ld_data = i_rd_word;
    endcase
  end

  always_comb begin
    o_wr_word = i_old_word;
    case (i_size)
      SZ_BYTE: o_wr_word[{i_offset, 3'b000} +: 8]     = i_st_data[7:0];
      SZ_HALF: o_wr_word[{i_offset[1], 4'b0000} +: 16] = i_st_data[15:0];
      default: o_wr_word = i_st_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : One-at-a-time load/store sequencer in front of a byte-addressed
//            32-bit memory. Word-aligned memory port, read-modify-write for
//            byte/half stores, sign/zero-extended loads, misalignment flag.
// Ports    : clk, rst_n (async, active-low)
//            req/we/size/uns/addr/wdata  - request side (accepted when ready)
//            ready/done/err/rdata        - response side
//            mem_adr/mem_d_in/mem_mrd/mem_mwr/mem_d_out - memory side
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_acc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_d_in,
  output logic              mem_mrd,
  output logic              mem_mwr,
  input  logic [31:0]       mem_d_out
);

  state_t            r_state;
  state_t            w_next;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic [31:0]       r_rdata;

  logic [31:0]       w_ld_data;
  logic [31:0]       w_wr_word;
  logic              w_bad_req;

  assign w_bad_req = (size == SZ_ILL) || is_misaligned(size, addr[1:0]);

  // State register. Asynchronous reset drops mem_mrd/mem_mwr straight away
  // because those outputs decode from r_state only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (w_bad_req) begin
            w_next = ST_ERR;
          end else if (we && (size == SZ_WORD)) begin
            w_next = ST_WR;
          end else begin
            // Loads and sub-word stores both start with a read.
            w_next = ST_RD;
          end
        end
      end
      ST_RD:   w_next = r_we ? ST_WR : ST_RESP;
      ST_WR:   w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_word  <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      if ((r_state == ST_IDLE) && req) begin
        r_we    <= we;
        r_size  <= size;
        r_uns   <= uns;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      if (r_state == ST_RD) begin
        r_word <= mem_d_out;
        // rdata is loaded on the RD->RESP edge so it is stable all of RESP.
        if (!r_we) begin
          r_rdata <= w_ld_data;
        end
      end
    end
  end

  lane_mux u_lane_mux (
    .i_size     (r_size),
    .i_offset   (r_addr[1:0]),
    .i_uns      (r_uns),
    .i_rd_word  (mem_d_out),
    .i_old_word (r_word),
    .i_st_data  (r_wdata),
    .o_ld_data  (w_ld_data),
    .o_wr_word  (w_wr_word)
  );

  assign ready    = (r_state == ST_IDLE);
  assign done     = (r_state == ST_RESP) || (r_state == ST_ERR);
  assign err      = (r_state == ST_ERR);
  assign rdata    = r_rdata;
  assign mem_mrd  = (r_state == ST_RD);
  assign mem_mwr  = (r_state == ST_WR);
  assign mem_adr  = (mem_mrd || mem_mwr) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_d_in = mem_mwr ? w_wr_word : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit with a behavioural
//            memory and a reference word array for expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, done, err, mem_mrd, mem_mwr;
  logic [31:0] rdata, mem_adr, mem_d_in, mem_d_out;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_rdata = 32'h0;
  logic        tb_init = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_adr(mem_adr), .mem_d_in(mem_d_in),
    .mem_mrd(mem_mrd), .mem_mwr(mem_mwr), .mem_d_out(mem_d_out)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 64) return 32'h8899AABB;
    if (i == 65) return 32'h11223344;
    return (i * 32'h01010101) ^ 32'hA5C30F96;
  endfunction

  // Behavioural memory: combinational read, commit on the edge ending a write.
  assign mem_d_out = mem_mrd ? mem[mem_adr[9:2]] : 32'h0;
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_mwr) begin
      mem[mem_adr[9:2]] <= mem_d_in;
    end
  end

  function automatic logic ref_bad(logic [1:0] sz, logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] sz, logic u, logic [31:0] a);
    logic [31:0] v;
    int off;
    off = int'(a % 4);
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!u && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] w, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd2) return d;
    sh   = (sz == 2'd0) ? 8 * int'(a % 4) : 16 * int'((a % 4) / 2);
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // Drives one request and observes it until done (bounded).
  task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic t_uns,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         output int d_cyc, output logic d_err, output int n_rd,
                         output int n_wr, output int rd_at, output int wr_at,
                         output logic port_bad, output logic rdy_ok);
    d_cyc = -1; d_err = 1'b0; n_rd = 0; n_wr = 0; rd_at = -1; wr_at = -1;
    port_bad = 1'b0;
    @(negedge clk);
    rdy_ok = ready;
    req = 1'b1; we = t_we; size = t_size; uns = t_uns; addr = t_addr; wdata = t_wdata;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    for (int c = 1; c <= 8 && d_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_mrd) begin
        n_rd++; rd_at = c;
        if (mem_adr !== (t_addr & ~32'h3)) port_bad = 1'b1;
      end
      if (mem_mwr) begin
        n_wr++; wr_at = c;
        if (mem_adr !== (t_addr & ~32'h3)) port_bad = 1'b1;
      end
      if (!mem_mrd && !mem_mwr && (mem_adr !== 32'h0 || mem_d_in !== 32'h0)) port_bad = 1'b1;
      if (done) begin
        d_cyc = c; d_err = err;
      end
    end
  endtask

  int dc, nr, nw, ra, wa;
  logic de, pb, ro;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    tb_init = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ready, done, err, mem_mrd, mem_mwr} !== 5'b10000 || rdata !== 32'h0 || mem_adr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: rdy/done/err/mrd/mwr=%b rdata=%h adr=%h, want 10000 0 0",
               {ready, done, err, mem_mrd, mem_mwr}, rdata, mem_adr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    run_txn(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, dc, de, nr, nw, ra, wa, pb, ro);
    n_tests++;
    if (rdata !== 32'h11223344 || dc !== 2) begin
      n_fail++; $display("FAIL pre_reset_lw: rdata=%h cyc=%0d, want 11223344 2", rdata, dc);
    end
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h100; wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req = 1'b0;
    n_tests++;
    if (mem_mwr !== 1'b1) begin
      n_fail++; $display("FAIL sw_in_wr: mem_mwr=%b, want 1", mem_mwr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_mwr !== 1'b0 || ready !== 1'b1 || rdata !== 32'h0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wr: mwr=%b ready=%b done=%b rdata=%h, want 0 1 0 0",
               mem_mwr, ready, done, rdata);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (mem[64] !== 32'h8899AABB) begin
      n_fail++; $display("FAIL reset_no_commit: mem=%h, want 8899aabb", mem[64]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = 32'h0;
  endtask

  task automatic test_byte_load();
    run_txn(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, dc, de, nr, nw, ra, wa, pb, ro);
    n_tests++;
    if (rdata !== 32'hFFFFFFAA || dc !== 2 || pb !== 1'b0 || nr !== 1 || de !== 1'b0) begin
      n_fail++;
      $display("FAIL lb: rdata=%h cyc=%0d port_bad=%b reads=%0d err=%b, want ffffffaa 2 0 1 0",
               rdata, dc, pb, nr, de);
    end
    run_txn(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, dc, de, nr, nw, ra, wa, pb, ro);
    n_tests++;
    if (rdata !== 32'h000000AA || dc !== 2) begin
      n_fail++; $display("FAIL lbu: rdata=%h cyc=%0d, want 000000aa 2", rdata, dc);
    end
  endtask

  task automatic test_subword_store();
    run_txn(1'b1, 2'd0, 1'b0, 32'h103, 32'h11, dc, de, nr, nw, ra, wa, pb, ro);
    n_tests++;
    if (mem[64] !== 32'h1199AABB || dc !== 3 || nw !== 1 || nr !== 1 || !(ra < wa) || pb !== 1'b0) begin
      n_fail++;
      $display("FAIL sb: mem=%h cyc=%0d wr=%0d rd=%0d rd_at=%0d wr_at=%0d port_bad=%b, want 1199aabb 3 1 1 rd<wr 0",
               mem[64], dc, nw, nr, ra, wa, pb);
    end
    run_txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234, dc, de, nr, nw, ra, wa, pb, ro);
    n_tests++;
    if (mem[64] !== 32'h1234AABB || dc !== 3 || nw !== 1) begin
      n_fail++; $display("FAIL sh: mem=%h cyc=%0d wr=%0d, want 1234aabb 3 1", mem[64], dc, nw);
    end
    run_txn(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, dc, de, nr, nw, ra, wa, pb, ro);
    n_tests++;
    if (rdata !== 32'hFFFFAABB || dc !== 2) begin
      n_fail++; $display("FAIL lh: rdata=%h cyc=%0d, want ffffaabb 2", rdata, dc);
    end
    run_txn(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, dc, de, nr, nw, ra, wa, pb, ro);
    n_tests++;
    if (rdata !== 32'h0000AABB || dc !== 2) begin
      n_fail++; $display("FAIL lhu: rdata=%h cyc=%0d, want 0000aabb 2", rdata, dc);
    end
    ref_mem[64] = 32'h1234AABB;
    ref_rdata   = 32'h0000AABB;
  endtask

  task automatic test_errors();
    logic        e_we   [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  e_size [3] = '{2'd2, 2'd1, 2'd3};
    logic [31:0] e_addr [3] = '{32'h102, 32'h101, 32'h100};
    for (int k = 0; k < 3; k++) begin
      run_txn(e_we[k], e_size[k], 1'b0, e_addr[k], 32'hCAFEF00D, dc, de, nr, nw, ra, wa, pb, ro);
      n_tests++;
      if (de !== 1'b1 || dc !== 1 || nr !== 0 || nw !== 0 || mem[64] !== ref_mem[64] || rdata !== ref_rdata) begin
        n_fail++;
        $display("FAIL err_case%0d: err=%b cyc=%0d rd=%0d wr=%0d mem=%h rdata=%h, want 1 1 0 0 %h %h",
                 k, de, dc, nr, nw, mem[64], rdata, ref_mem[64], ref_rdata);
      end
    end
  endtask

  task automatic test_req_held();
    logic [31:0] exp_a, exp_b;
    int c2;
    exp_a = ref_mem[64];
    exp_b = ref_mem[65];
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b0 || mem_mrd !== 1'b1 || mem_adr !== 32'h100) begin
      n_fail++; $display("FAIL held_busy: ready=%b mrd=%b adr=%h, want 0 1 100", ready, mem_mrd, mem_adr);
    end
    addr = 32'h108;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || rdata !== exp_a) begin
      n_fail++; $display("FAIL held_first: done=%b rdata=%h, want 1 %h", done, rdata, exp_a);
    end
    addr = 32'h104;
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL held_ready: ready=%b, want 1", ready);
    end
    @(posedge clk);
    #1 req = 1'b0;
    c2 = -1;
    for (int c = 1; c <= 8 && c2 < 0; c++) begin
      @(negedge clk);
      if (done) c2 = c;
    end
    n_tests++;
    if (c2 !== 2 || rdata !== exp_b) begin
      n_fail++; $display("FAIL held_second: cyc=%0d rdata=%h, want 2 %h", c2, rdata, exp_b);
    end
    ref_rdata = exp_b;
  endtask

  task automatic test_random();
    logic        r_we, r_uns, bad;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wd, exp_word;
    int          idx, exp_cyc;
    for (int t = 0; t < 40; t++) begin
      r_we   = 1'($urandom);
      r_size = 2'($urandom_range(0, 3));
      r_uns  = 1'($urandom);
      r_addr = 32'h100 + $urandom_range(0, 63);
      r_wd   = $urandom;
      idx    = int'(r_addr[9:2]);
      bad    = ref_bad(r_size, r_addr);
      exp_word = ref_mem[idx];
      if (!bad && r_we) exp_word = ref_store(ref_mem[idx], r_size, r_addr, r_wd);
      if (!bad && !r_we) ref_rdata = ref_load(ref_mem[idx], r_size, r_uns, r_addr);
      exp_cyc = bad ? 1 : ((r_we && r_size != 2'd2) ? 3 : 2);
      run_txn(r_we, r_size, r_uns, r_addr, r_wd, dc, de, nr, nw, ra, wa, pb, ro);
      ref_mem[idx] = exp_word;
      n_tests++;
      if (dc !== exp_cyc || de !== bad || rdata !== ref_rdata || mem[idx] !== exp_word ||
          pb !== 1'b0 || ro !== 1'b1 || nw !== ((!bad && r_we) ? 1 : 0) ||
          nr !== ((!bad && !(r_we && r_size == 2'd2)) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL rand%0d we=%b sz=%0d a=%h: cyc=%0d err=%b rdata=%h mem=%h rd=%0d wr=%0d pb=%b rdy=%b, want cyc=%0d err=%b rdata=%h mem=%h",
                 t, r_we, r_size, r_addr, dc, de, rdata, mem[idx], nr, nw, pb, ro,
                 exp_cyc, bad, ref_rdata, exp_word);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_reset_mid_write();
    test_byte_load();
    test_subword_store();
    test_errors();
    test_req_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
